// File: rtl/des_dec_key_sched_pkg.sv
// Shared DES key-schedule tables (FIPS 46-3) used by the encrypt and decrypt schedulers.
// Table entries are 1-based FIPS bit numbers; bit 1 is the MSB of each vector.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Encrypt-order left-rotation amounts for rounds 1..16.
  localparam int SHIFT [DES_ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } sched_state_e;

  // Decrypt step idx undoes the encrypt rotation of round 16-idx.
  function automatic logic rshift_is_one(input logic [3:0] idx);
    return SHIFT[DES_ROUNDS-1-int'(idx)] == 1;
  endfunction

endpackage

// File: rtl/des_dec_key_sched_if.sv
// Load/handshake bundle between the key scheduler and its requester/consumer.
interface des_dec_key_sched_if;
  logic        start;
  logic [63:0] key;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [4:0]  round;
  logic        busy;
  logic        done;

  modport master (
    output start, key, subkey_ready,
    input  subkey, subkey_valid, round, busy, done
  );

  modport slave (
    input  start, key, subkey_ready,
    output subkey, subkey_valid, round, busy, done
  );
endinterface

// File: rtl/des_dec_key_sched_pc2.sv
// PC-2 permutation: 56-bit {C,D} to 48-bit subkey, pure wiring.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] k
);

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign k[47-i] = cd[56-PC2[i]];
  end

endmodule

// File: rtl/des_dec_key_sched.sv
// Iterative DES decryption key scheduler: emits K16..K1, one per valid/ready transfer.
module des_dec_key_sched
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  des_dec_key_sched_if.slave  bus
);

  logic [55:0]  key_pc1;
  sched_state_e state_q, state_d;
  logic [27:0]  c_q, c_d, d_q, d_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign key_pc1[55-i] = bus.key[64-PC1[i]];
  end

  // C16/D16 equal C0/D0, so the loaded PC-1 value already yields K16.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          c_d     = key_pc1[55:28];
          d_d     = key_pc1[27:0];
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.subkey_ready) begin
          if (idx_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            if (rshift_is_one(idx_q)) begin
              c_d = {c_q[0], c_q[27:1]};
              d_d = {d_q[0], d_q[27:1]};
            end else begin
              c_d = {c_q[1:0], c_q[27:2]};
              d_d = {d_q[1:0], d_q[27:2]};
            end
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd ({c_q, d_q}),
    .k  (bus.subkey)
  );

  assign bus.subkey_valid = (state_q == EMIT);
  assign bus.busy         = (state_q == EMIT);
  assign bus.done         = done_q;
  assign bus.round        = (state_q == EMIT) ? (5'd16 - {1'b0, idx_q}) : 5'd0;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched: known-answer table, randomized ready/keys vs. an encrypt-order model.
module tb_des_dec_key_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  des_dec_key_sched_if bus ();

  des_dec_key_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int T_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int T_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int T_SH [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef logic [47:0] sk_arr_t [16];

  // Forward (encrypt-order) schedule on 1-based bit arrays: K1..K16 in [0..15].
  function automatic sk_arr_t ref_sched(input logic [63:0] k);
    sk_arr_t ks;
    bit kb [65];
    bit c [29];
    bit d [29];
    bit tc, td;
    for (int n = 1; n <= 64; n++) kb[n] = k[64-n];
    for (int i = 0; i < 28; i++) begin
      c[i+1] = kb[T_PC1[i]];
      d[i+1] = kb[T_PC1[i+28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < T_SH[r]; s++) begin
        tc = c[1];
        td = d[1];
        for (int j = 1; j < 28; j++) begin
          c[j] = c[j+1];
          d[j] = d[j+1];
        end
        c[28] = tc;
        d[28] = td;
      end
      for (int i = 0; i < 48; i++)
        ks[r][47-i] = (T_PC2[i] <= 28) ? c[T_PC2[i]] : d[T_PC2[i]-28];
    end
    return ks;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Starts a schedule at a negedge and consumes it with random ready.
  // stop_rnd != 0 returns early (mid-schedule) once that round is presented.
  task automatic run_schedule(input logic [63:0] k, input int pct, input bit inj9,
                              input int stop_rnd, output logic [47:0] first,
                              output logic [47:0] last, output int done_cyc);
    sk_arr_t e;
    int n, cyc;
    bit stalled, rdy;
    logic [47:0] psk;
    logic [4:0] prnd;
    e = ref_sched(k);
    first = '0;
    last = '0;
    done_cyc = -1;
    bus.key = k;
    bus.start = 1'b1;
    bus.subkey_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key = {$urandom, $urandom};
    n = 0;
    cyc = 1;
    stalled = 1'b0;
    psk = '0;
    prnd = '0;
    while (n < 16 && cyc < 400) begin
      bus.start = 1'b0;
      if (stop_rnd != 0 && int'(bus.round) == stop_rnd) return;
      chk("valid", 64'(bus.subkey_valid), 64'd1);
      chk("no_early_done", 64'(bus.done), 64'd0);
      if (stalled) begin
        chk("stall_subkey", 64'(bus.subkey), 64'(psk));
        chk("stall_round", 64'(bus.round), 64'(prnd));
      end
      rdy = int'($urandom_range(99)) < pct;
      if (inj9 && int'(bus.round) == 9) begin
        bus.start = 1'b1;
        bus.key = '1;
      end
      bus.subkey_ready = rdy;
      if (rdy) begin
        chk("round", 64'(bus.round), 64'(16 - n));
        chk("subkey", 64'(bus.subkey), 64'(e[15-n]));
        if (n == 0) first = bus.subkey;
        if (n == 15) last = bus.subkey;
        n++;
      end
      stalled = !rdy;
      psk = bus.subkey;
      prnd = bus.round;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.subkey_ready = 1'b0;
    if (n < 16) chk("timeout_transfers", 64'(n), 64'd16);
    done_cyc = cyc;
    chk("done", 64'(bus.done), 64'd1);
    chk("done_valid", 64'(bus.subkey_valid), 64'd0);
    chk("done_busy", 64'(bus.busy), 64'd0);
    chk("done_round", 64'(bus.round), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  typedef struct {
    logic [63:0] key;
    int          pct;
    logic [47:0] first;
    logic [47:0] last;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    logic [47:0] f, l;
    int dc;
    sk_arr_t e2;
    logic [63:0] k2;
    bit found;

    vecs[0] = '{64'h133457799BBCDFF1, 100, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[1] = '{64'h133457799BBCDFF1,  50, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[2] = '{64'h123556789ABDDEF0,  70, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[3] = '{64'h0000000000000000, 100, 48'h000000000000, 48'h000000000000};
    vecs[4] = '{64'hFFFFFFFFFFFFFFFF,  30, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};

    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    bus.subkey_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_subkey", 64'(bus.subkey), 64'd0);
    chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
    chk("rst_round", 64'(bus.round), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_schedule(vecs[v].key, vecs[v].pct, 1'b0, 0, f, l, dc);
      chk($sformatf("vec%0d_first", v), 64'(f), 64'(vecs[v].first));
      chk($sformatf("vec%0d_last", v), 64'(l), 64'(vecs[v].last));
      if (vecs[v].pct == 100) chk($sformatf("vec%0d_done_cycle", v), 64'(dc), 64'd17);
    end

    // Start with an all-ones key while round 9 is presented must be ignored.
    run_schedule(64'h133457799BBCDFF1, 60, 1'b1, 0, f, l, dc);
    chk("inject_first", 64'(f), 64'hCB3D8B0E17F5);
    chk("inject_last", 64'(l), 64'h1B02EFFC7072);

    // Reset at round 5: outputs clear immediately and no done follows.
    run_schedule(64'h0E329232EA6D0D73, 100, 1'b0, 5, f, l, dc);
    chk("pre_rst_round", 64'(bus.round), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_subkey", 64'(bus.subkey), 64'd0);
    chk("mid_rst_valid", 64'(bus.subkey_valid), 64'd0);
    chk("mid_rst_round", 64'(bus.round), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.subkey_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 64'(bus.done), 64'd0);
    chk("post_rst_valid", 64'(bus.subkey_valid), 64'd0);
    run_schedule(64'h0, 100, 1'b0, 0, f, l, dc);
    chk("zero_first", 64'(f), 64'd0);
    chk("zero_last", 64'(l), 64'd0);

    // Random keys with random backpressure.
    for (int r = 0; r < 6; r++) begin
      k2 = {$urandom, $urandom};
      e2 = ref_sched(k2);
      run_schedule(k2, int'($urandom_range(90, 20)), r[0], 0, f, l, dc);
      chk($sformatf("rand%0d_first", r), 64'(f), 64'(e2[15]));
      chk($sformatf("rand%0d_last", r), 64'(l), 64'(e2[0]));
    end

    // Back-to-back: start held high, second schedule begins right after done.
    k2 = 64'hA5A5_5A5A_0F0F_F0F0;
    e2 = ref_sched(k2);
    bus.key = 64'h133457799BBCDFF1;
    bus.start = 1'b1;
    bus.subkey_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) @(negedge clk);
    chk("b2b_done", 64'(bus.done), 64'd1);
    bus.key = k2;
    @(negedge clk);
    chk("b2b_valid", 64'(bus.subkey_valid), 64'd1);
    chk("b2b_round", 64'(bus.round), 64'd16);
    chk("b2b_k16", 64'(bus.subkey), 64'(e2[15]));
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.done) found = 1'b1;
    end
    chk("b2b_second_done", 64'(found), 64'd1);
    bus.subkey_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
